// File: rtl/vga_pkg.sv
// Shared types and default timing for the VGA test-pattern generator.
package vga_pkg;

   typedef enum logic [1:0] {
      PAT_BARS  = 2'd0,
      PAT_CHECK = 2'd1,
      PAT_BOX   = 2'd2,
      PAT_OFF   = 2'd3
   } pat_e;

   localparam int H_ACT = 640;
   localparam int V_ACT = 480;

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position for the BOX pattern; advances one step per frame tick.
module vga_box_mover
   import vga_pkg::*;
#(
   parameter int H_ACT    = vga_pkg::H_ACT,
   parameter int V_ACT    = vga_pkg::V_ACT,
   parameter int BOX_SIZE = 32,
   parameter int BOX_STEP = 2
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_frame_tick,
   output logic [9:0] o_bx,
   output logic [9:0] o_by
);

   localparam logic [10:0] X_MAX = 11'(H_ACT - BOX_SIZE);
   localparam logic [10:0] Y_MAX = 11'(V_ACT - BOX_SIZE);
   localparam logic [10:0] STEP  = 11'(BOX_STEP);

   logic [9:0] r_bx;
   logic [9:0] r_by;
   logic       r_dx;
   logic       r_dy;

   // 11-bit compares keep bx+STEP from wrapping near the right/bottom edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bx <= '0;
         r_by <= '0;
         r_dx <= 1'b1;
         r_dy <= 1'b1;
      end else if (i_frame_tick) begin
         if (r_dx) begin
            if (({1'b0, r_bx} + STEP) >= X_MAX) begin
               r_bx <= X_MAX[9:0];
               r_dx <= 1'b0;
            end else begin
               r_bx <= r_bx + STEP[9:0];
            end
         end else if ({1'b0, r_bx} <= STEP) begin
            r_bx <= '0;
            r_dx <= 1'b1;
         end else begin
            r_bx <= r_bx - STEP[9:0];
         end

         if (r_dy) begin
            if (({1'b0, r_by} + STEP) >= Y_MAX) begin
               r_by <= Y_MAX[9:0];
               r_dy <= 1'b0;
            end else begin
               r_by <= r_by + STEP[9:0];
            end
         end else if ({1'b0, r_by} <= STEP) begin
            r_by <= '0;
            r_dy <= 1'b1;
         end else begin
            r_by <= r_by - STEP[9:0];
         end
      end
   end

   assign o_bx = r_bx;
   assign o_by = r_by;

endmodule

// File: rtl/vga_patgen.sv
// Test-pattern pixel generator: tracks position from syncgen timing and emits
// 1-bit RGB plus re-registered syncs, all advancing on the vga_clk_en strobe.
module vga_patgen
   import vga_pkg::*;
#(
   parameter int H_ACT     = vga_pkg::H_ACT,
   parameter int V_ACT     = vga_pkg::V_ACT,
   parameter int BAR_W     = 80,
   parameter int CHK_SHIFT = 5,
   parameter int BOX_SIZE  = 32,
   parameter int BOX_STEP  = 2
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       vga_clk_en,
   input  logic       i_hsync,
   input  logic       i_vsync,
   input  logic       i_vga_act,
   input  logic [1:0] i_pat_sel,
   output logic       o_hsync,
   output logic       o_vsync,
   output logic       o_vga_act,
   output logic       o_analog_r,
   output logic       o_analog_g,
   output logic       o_analog_b
);

   localparam int BW = $clog2(BAR_W);

   logic [9:0]    r_x;
   logic [9:0]    r_y;
   logic [BW-1:0] r_bar_cnt;
   logic [2:0]    r_bar_idx;
   logic          r_vs_d;
   logic          r_act_d;
   pat_e          r_pat;
   logic          r_hsync;
   logic          r_vsync;
   logic          r_vga_act;
   logic [2:0]    r_rgb;

   logic [9:0]    w_bx;
   logic [9:0]    w_by;
   logic          w_vs_fall;
   logic          w_act_fall;
   logic          w_frame_tick;
   logic          w_in_box;
   logic          w_chk;
   logic [2:0]    w_pat_rgb;
   logic [2:0]    w_rgb;

   assign w_vs_fall    = r_vs_d & ~i_vsync;
   assign w_act_fall   = r_act_d & ~i_vga_act;
   assign w_frame_tick = vga_clk_en & w_vs_fall;

   vga_box_mover #(
      .H_ACT    (H_ACT),
      .V_ACT    (V_ACT),
      .BOX_SIZE (BOX_SIZE),
      .BOX_STEP (BOX_STEP)
   ) u_box (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_frame_tick (w_frame_tick),
      .o_bx         (w_bx),
      .o_by         (w_by)
   );

   // bar_idx saturates so an over-long active pulse stays black instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x       <= '0;
         r_bar_cnt <= '0;
         r_bar_idx <= '0;
      end else if (vga_clk_en) begin
         if (i_vga_act) begin
            r_x <= r_x + 10'd1;
            if (r_bar_cnt == BW'(BAR_W - 1)) begin
               r_bar_cnt <= '0;
               if (r_bar_idx != 3'd7) begin
                  r_bar_idx <= r_bar_idx + 3'd1;
               end
            end else begin
               r_bar_cnt <= r_bar_cnt + 1'b1;
            end
         end else begin
            r_x       <= '0;
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y     <= '0;
         r_vs_d  <= 1'b1;
         r_act_d <= 1'b0;
         r_pat   <= PAT_BARS;
      end else if (vga_clk_en) begin
         r_vs_d  <= i_vsync;
         r_act_d <= i_vga_act;
         if (w_vs_fall) begin
            r_y   <= '0;
            r_pat <= pat_e'(i_pat_sel);
         end else if (w_act_fall) begin
            r_y <= r_y + 10'd1;
         end
      end
   end

   always_comb begin
      w_in_box  = ({1'b0, r_x} >= {1'b0, w_bx}) &&
                  ({1'b0, r_x} <  ({1'b0, w_bx} + 11'(BOX_SIZE))) &&
                  ({1'b0, r_y} >= {1'b0, w_by}) &&
                  ({1'b0, r_y} <  ({1'b0, w_by} + 11'(BOX_SIZE)));
      w_chk     = r_x[CHK_SHIFT] ^ r_y[CHK_SHIFT];
      w_pat_rgb = 3'b000;
      case (r_pat)
         PAT_BARS:  w_pat_rgb = {~r_bar_idx[1], ~r_bar_idx[2], ~r_bar_idx[0]};
         PAT_CHECK: w_pat_rgb = {3{w_chk}};
         PAT_BOX:   w_pat_rgb = w_in_box ? 3'b111 : 3'b001;
         default:   w_pat_rgb = 3'b000;
      endcase
      w_rgb = i_vga_act ? w_pat_rgb : 3'b000;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hsync   <= 1'b1;
         r_vsync   <= 1'b1;
         r_vga_act <= 1'b0;
         r_rgb     <= 3'b000;
      end else if (vga_clk_en) begin
         r_hsync   <= i_hsync;
         r_vsync   <= i_vsync;
         r_vga_act <= i_vga_act;
         r_rgb     <= w_rgb;
      end
   end

   assign o_hsync    = r_hsync;
   assign o_vsync    = r_vsync;
   assign o_vga_act  = r_vga_act;
   assign o_analog_r = r_rgb[2];
   assign o_analog_g = r_rgb[1];
   assign o_analog_b = r_rgb[0];

endmodule

// File: tb/tb_vga_patgen.sv
// Directed self-checking bench for vga_patgen: reset, bars, pattern latch,
// checkerboard, mid-frame reset, strobe gating, simultaneous edges and box bounce.
module tb_vga_patgen;
   import vga_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       vga_clk_en;
   logic       i_hsync;
   logic       i_vsync;
   logic       i_vga_act;
   logic [1:0] i_pat_sel;
   logic       o_hsync;
   logic       o_vsync;
   logic       o_vga_act;
   logic       o_analog_r;
   logic       o_analog_g;
   logic       o_analog_b;

   int testsRun    = 0;
   int testsFailed = 0;
   int nFrames     = 0;

   localparam logic [2:0] BAR_RGB [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                          3'b101, 3'b100, 3'b001, 3'b000};

   // Probe points: frame count after reset, expected bx, expected by.
   localparam int N_PROBES = 6;
   localparam int PROBE_N  [N_PROBES] = '{1,   224, 225, 304, 305, 400};
   localparam int PROBE_BX [N_PROBES] = '{2,   448, 450, 608, 606, 416};
   localparam int PROBE_BY [N_PROBES] = '{2,   448, 446, 288, 286, 96};

   vga_patgen dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .vga_clk_en (vga_clk_en),
      .i_hsync    (i_hsync),
      .i_vsync    (i_vsync),
      .i_vga_act  (i_vga_act),
      .i_pat_sel  (i_pat_sel),
      .o_hsync    (o_hsync),
      .o_vsync    (o_vsync),
      .o_vga_act  (o_vga_act),
      .o_analog_r (o_analog_r),
      .o_analog_g (o_analog_g),
      .o_analog_b (o_analog_b)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rgbOut();
      return {29'd0, o_analog_r, o_analog_g, o_analog_b};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // One strobe with the given inputs followed by one idle (non-strobe) clock.
   task automatic applyStimulus(input logic hs, input logic vs, input logic act);
      i_hsync    = hs;
      i_vsync    = vs;
      i_vga_act  = act;
      vga_clk_en = 1'b1;
      @(posedge clk);
      #1;
      vga_clk_en = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic shortLine();
      applyStimulus(1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0);
   endtask

   task automatic frameTick();
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      nFrames++;
   endtask

   task automatic probeBox(input int bx, input int by);
      int len;
      logic [2:0] exp;
      len = (bx + 33 > 640) ? 640 : bx + 33;
      for (int r = 0; r <= by + 32; r++) begin
         if (r == by - 1 || r == by || r == by + 31 || r == by + 32) begin
            for (int x = 0; x < len; x++) begin
               applyStimulus(1'b1, 1'b1, 1'b1);
               if (x == bx - 1 || x == bx || x == bx + 31 || x == bx + 32) begin
                  exp = (x >= bx && x < bx + 32 && r >= by && r < by + 32) ? 3'b111 : 3'b001;
                  checkOutput($sformatf("box_n%0d_x%0d_y%0d", nFrames, x, r), rgbOut(), 32'(exp));
               end
            end
            applyStimulus(1'b1, 1'b1, 1'b0);
         end else begin
            shortLine();
         end
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      vga_clk_en = 1'b0;
      i_hsync    = 1'b1;
      i_vsync    = 1'b1;
      i_vga_act  = 1'b0;
      i_pat_sel  = 2'd0;
      @(posedge clk);
      #1;

      // Reset held with random inputs.
      for (int k = 0; k < 4; k++) begin
         i_pat_sel = 2'($urandom_range(0, 3));
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
         checkOutput("rst_hsync", 32'(o_hsync), 32'd1);
         checkOutput("rst_vsync", 32'(o_vsync), 32'd1);
         checkOutput("rst_act", 32'(o_vga_act), 32'd0);
         checkOutput("rst_rgb", rgbOut(), 32'd0);
      end
      rst_n     = 1'b1;
      i_pat_sel = 2'd0;

      // Colour bars, with an over-long active pulse and a gated gap mid-line.
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("pre_act", 32'(o_vga_act), 32'd0);
      checkOutput("pre_rgb", rgbOut(), 32'd0);
      for (int p = 0; p < 700; p++) begin
         applyStimulus(1'b1, 1'b1, 1'b1);
         checkOutput($sformatf("bars_p%0d", p), rgbOut(), 32'(BAR_RGB[p >= 640 ? 7 : p / 80]));
         if (p == 0 || p == 699) checkOutput($sformatf("bars_act_p%0d", p), 32'(o_vga_act), 32'd1);
         if (p == 300) begin
            i_vga_act = 1'b0;
            i_vsync   = 1'b0;
            i_hsync   = 1'b0;
            repeat (100) @(posedge clk);
            #1;
            checkOutput("gate_rgb", rgbOut(), 32'(3'b010));
            checkOutput("gate_act", 32'(o_vga_act), 32'd1);
            checkOutput("gate_hsync", 32'(o_hsync), 32'd1);
            checkOutput("gate_vsync", 32'(o_vsync), 32'd1);
         end
      end
      for (int k = 0; k < 20; k++) begin
         applyStimulus((k >= 5 && k < 15) ? 1'b0 : 1'b1, 1'b1, 1'b0);
         checkOutput($sformatf("blank_rgb_%0d", k), rgbOut(), 32'd0);
         checkOutput($sformatf("blank_hsync_%0d", k), 32'(o_hsync), (k >= 5 && k < 15) ? 32'd0 : 32'd1);
         if (k == 0) checkOutput("blank_act", 32'(o_vga_act), 32'd0);
      end

      // Pattern select changes mid-frame: bars continue until the frame edge.
      i_pat_sel = 2'd1;
      for (int x = 0; x < 40; x++) begin
         applyStimulus(1'b1, 1'b1, 1'b1);
         if (x == 0) checkOutput("latch_hold_x0", rgbOut(), 32'(3'b111));
      end
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("vsync_low", 32'(o_vsync), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("vsync_high", 32'(o_vsync), 32'd1);

      // Checkerboard frame.
      for (int x = 0; x < 40; x++) begin
         applyStimulus(1'b1, 1'b1, 1'b1);
         if (x == 0)  checkOutput("chk_x0_y0", rgbOut(), 32'(3'b000));
         if (x == 31) checkOutput("chk_x31_y0", rgbOut(), 32'(3'b000));
         if (x == 32) checkOutput("chk_x32_y0", rgbOut(), 32'(3'b111));
      end
      applyStimulus(1'b1, 1'b1, 1'b0);
      for (int r = 1; r < 32; r++) shortLine();
      for (int x = 0; x < 40; x++) begin
         applyStimulus(1'b1, 1'b1, 1'b1);
         if (x == 0)  checkOutput("chk_x0_y32", rgbOut(), 32'(3'b111));
         if (x == 32) checkOutput("chk_x32_y32", rgbOut(), 32'(3'b000));
      end
      applyStimulus(1'b1, 1'b1, 1'b0);

      // Asynchronous reset in the middle of line 33.
      for (int x = 0; x < 5; x++) applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("pre_reset_rgb", rgbOut(), 32'(3'b111));
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_hsync", 32'(o_hsync), 32'd1);
      checkOutput("midrst_vsync", 32'(o_vsync), 32'd1);
      checkOutput("midrst_act", 32'(o_vga_act), 32'd0);
      checkOutput("midrst_rgb", rgbOut(), 32'd0);
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("midrst_hold_rgb", rgbOut(), 32'd0);
      rst_n = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0);
      for (int x = 0; x < 81; x++) begin
         applyStimulus(1'b1, 1'b1, 1'b1);
         if (x == 0)  checkOutput("postrst_bars_x0", rgbOut(), 32'(3'b111));
         if (x == 80) checkOutput("postrst_bars_x80", rgbOut(), 32'(3'b110));
      end
      applyStimulus(1'b1, 1'b1, 1'b0);

      // Bring y to 31, then end line 31 with act and vsync falling together.
      for (int r = 1; r < 31; r++) shortLine();
      for (int x = 0; x < 4; x++) applyStimulus(1'b1, 1'b1, 1'b1);
      i_pat_sel = 2'd2;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("simul_rgb", rgbOut(), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      nFrames = 1;

      // Box bounce across 400 frames with probes near the turning points.
      for (int i = 0; i < N_PROBES; i++) begin
         while (nFrames < PROBE_N[i]) frameTick();
         probeBox(PROBE_BX[i], PROBE_BY[i]);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/vga_patgen.md
# vga_patgen

Test-pattern pixel generator placed between `syncgen` and the VGA pins inside `vga_ctrl`. It consumes the raw `hsync`/`vsync`/`vga_act` timing from `syncgen`, tracks pixel and line position, and produces 1-bit R/G/B for one of four selectable patterns. Sync and active outputs are re-registered so they stay aligned with the RGB outputs. The block runs on `clk50m`, and all state advances only on the `vga_clk_en` strobe from `timgen`.

## Interface
- `H_ACT`, 640: active pixels per line
- `V_ACT`, 480: active lines per frame
- `BAR_W`, 80: colour-bar width in pixels (8 bars)
- `CHK_SHIFT`, 5: checkerboard square is 2^CHK_SHIFT pixels
- `BOX_SIZE`, 32: moving-box edge length in pixels
- `BOX_STEP`, 2: box displacement per frame in pixels, on each axis
- `clk` in 1: pixel-domain system clock (`clk50m`)
- `rst_n` in 1: one clock; reset is asynchronous, active-low
- `vga_clk_en` in 1: pixel strobe from `timgen`
- `i_hsync`, `i_vsync` in 1: syncs from `syncgen`, active-low
- `i_vga_act` in 1: active-video flag from `syncgen`
- `i_pat_sel` in 2: requested pattern
- `o_hsync`, `o_vsync` out 1: delayed syncs, active-low
- `o_vga_act` out 1: delayed active flag
- `o_analog_r`, `o_analog_g`, `o_analog_b` out 1: pixel colour

## Operation
- **Strobe rule.** All registers update only in cycles where `vga_clk_en`=1. Outside those cycles every register holds its value.
- **Horizontal position.**
  - `x` (10 b) increments while `i_vga_act`=1 and clears to 0 while `i_vga_act`=0.
  - `bar_cnt` counts 0..BAR_W-1 alongside `x`. When it wraps, `bar_idx` (3 b) increments, saturating at 7. Both clear when `i_vga_act`=0.
- **Vertical position.**
  - `y` (10 b) increments on the falling edge of `i_vga_act`, detected with a registered previous value.
  - `y` clears to 0 on the falling edge of `i_vsync` (the frame edge). If both edges occur in the same strobe, the clear wins.
- **Frame edge.** On the falling edge of `i_vsync`:
  - `pat` is loaded from `i_pat_sel`. The pattern never changes mid-frame.
  - The box position is updated (see below).
- **Patterns** (encoding of `pat`):
  - BARS (0): r=~bar_idx[1], g=~bar_idx[2], b=~bar_idx[0]. This gives, left to right: white, yellow, cyan, green, magenta, red, blue, black.
  - CHECK (1): all three channels equal `x[CHK_SHIFT]^y[CHK_SHIFT]`.
  - BOX (2): white (111) when `bx<=x<bx+BOX_SIZE` and `by<=y<by+BOX_SIZE`; otherwise blue (001).
  - OFF (3): black (000).
- **Blanking.** RGB is forced to 000 whenever `i_vga_act`=0, regardless of pattern.
- **Box motion.**
  - State: `bx`, `by` (10 b each) and direction bits `dx`, `dy` (1 = increasing).
  - Moving up: if `bx+BOX_STEP >= H_ACT-BOX_SIZE`, then `bx <= H_ACT-BOX_SIZE` and `dx <= 0`; otherwise `bx += BOX_STEP`.
  - Moving down: if `bx <= BOX_STEP`, then `bx <= 0` and `dx <= 1`; otherwise `bx -= BOX_STEP`.
  - The y axis behaves identically using `V_ACT`.
  - Box motion runs every frame, whatever pattern is selected.
- **Arithmetic.** Comparisons use 11-bit unsigned values so nothing wraps. `BOX_SIZE` must be less than `V_ACT`.

## Timing
- **Latency.** Exactly one strobe. The `o_*` values presented after strobe N reflect the `i_*` values sampled at strobe N, and the RGB is computed from the `x`/`y` state before that strobe's update. The first active pixel therefore has `x`=0.
- **Sync alignment.** `o_hsync`, `o_vsync` and `o_vga_act` are plain one-strobe delays of their inputs, so they stay exactly aligned with the RGB outputs.
- **Reset values.**
  - Outputs: `o_hsync`=1, `o_vsync`=1, `o_vga_act`=0, RGB=000.
  - Internal: `x`=`y`=0, `bar_idx`=0, `pat`=BARS, `bx`=`by`=0, `dx`=`dy`=1, edge-detect registers = 1 (vsync) and 0 (act).
- **Reset mid-frame.** All state returns to the reset values immediately, asynchronously. The first frame after reset is rendered as BARS until the next vsync falling edge.
- **Long input pulses.** An `i_vga_act` pulse longer than H_ACT saturates `bar_idx` at 7 (black); `x` keeps counting and may wrap at 1024 without error.

## Structure
- **Package `vga_pkg`:**
  - `pat_e` enum (PAT_BARS, PAT_CHECK, PAT_BOX, PAT_OFF)
  - default timing constants `H_ACT` and `V_ACT`
- **Sub-module `vga_box_mover`:**
  - Inputs: `clk`, `rst_n`, `frame_tick`.
  - Outputs: `bx`, `by`.
  - Owns the position and direction registers and the bounce logic.
- **Top `vga_patgen`:** counters, edge detect, pattern mux and output registers.

## Test plan
- **Reset:** hold `rst_n`=0 with random inputs -> `o_hsync`=`o_vsync`=1, `o_vga_act`=0, RGB=000; release -> first frame is BARS.
- **Colour bars:** one 640-pixel active line with `pat`=BARS -> output pixels 0..79 are 111, 80..159 are 110, ..., 560..639 are 000; RGB is 000 on the blanking pixels; output lags input by exactly one strobe.
- **Pattern latch:** change `i_pat_sel` from 0 to 1 mid-frame -> output remains bars until after the next vsync falling edge; from the next frame, pixel (32,0)=111 and pixel (32,32)=000 (checkerboard).
- **Box bounce:** 400 vsync edges with `pat`=BOX -> `bx` sequence 0, 2, ..., 606, 608, 606, ...; `by` reaches 448 and then reverses; the white region measures exactly 32x32.
- **Strobe gating:** `vga_clk_en` held at 0 for 100 cycles mid-line -> all outputs and counters are frozen; after `vga_clk_en` resumes, the line completes with the same pixel values as an ungated run.
- **Simultaneous edges:** falling edges of `i_vsync` and `i_vga_act` in the same strobe -> `y`=0 afterwards, and the pattern and box update occur exactly once.
